// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU arbiter slice.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU: ADD/SUB/AND/OR with Zero/Negative/Carry/Overflow flags.
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] OperA,
    input  logic [WIDTH-1:0] OperB,
    input  logic [1:0]       ALU_Code,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
);

    logic             is_sub;
    logic             is_arith;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    always_comb begin
        is_sub   = (ALU_Code == ALU_SUB);
        is_arith = (ALU_Code == ALU_ADD) || is_sub;
        // SUB is A + ~B + 1 so both ops share one adder and one carry-out
        b_eff    = is_sub ? ~OperB : OperB;
        sum      = {1'b0, OperA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        case (ALU_Code)
            ALU_AND: Result = OperA & OperB;
            ALU_OR:  Result = OperA | OperB;
            default: Result = sum[WIDTH-1:0];
        endcase
        Carry    = is_arith & sum[WIDTH];
        Overflow = is_arith & (OperA[WIDTH-1] == b_eff[WIDTH-1])
                            & (Result[WIDTH-1] != OperA[WIDTH-1]);
        Zero     = (Result == '0);
        Negative = Result[WIDTH-1];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two valid/ready requesters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Req0_Valid,
    output logic             Req0_Ready,
    input  logic [WIDTH-1:0] Req0_OperA,
    input  logic [WIDTH-1:0] Req0_OperB,
    input  logic [1:0]       Req0_Code,
    input  logic             Req1_Valid,
    output logic             Req1_Ready,
    input  logic [WIDTH-1:0] Req1_OperA,
    input  logic [WIDTH-1:0] Req1_OperB,
    input  logic [1:0]       Req1_Code,
    output logic             Rsp_Valid,
    input  logic             Rsp_Ready,
    output logic             Rsp_Id,
    output logic [WIDTH-1:0] Rsp_Result,
    output logic [3:0]       Rsp_Flags,
    output logic [CNT_W-1:0] Op_Count,
    output logic             Busy
);

    state_e           state_q;
    logic             last_grant_q;
    logic             id_q;
    logic             rsp_id_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] oper_a_q;
    logic [WIDTH-1:0] oper_b_q;
    logic [1:0]       code_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [3:0]       flags_d;

    logic             grant;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] alu_result;
    logic             alu_z, alu_n, alu_c, alu_v;

    always_comb begin
        // With both requesting, the port that did not win last time goes next
        grant     = (Req0_Valid & Req1_Valid) ? ~last_grant_q : Req1_Valid;
        slot_free = Reset_n & ((state_q == ST_IDLE) | ((state_q == ST_RESP) & Rsp_Ready));
        accept    = slot_free & (Req0_Valid | Req1_Valid);
        Req0_Ready = slot_free & Req0_Valid & ~grant;
        Req1_Ready = slot_free & Req1_Valid & grant;
        count_d   = count_q + 1'b1;
        flags_d         = '0;
        flags_d[FLAG_Z] = alu_z;
        flags_d[FLAG_N] = alu_n;
        flags_d[FLAG_C] = alu_c;
        flags_d[FLAG_V] = alu_v;
    end

    always_ff @(posedge Clk) begin
        if (accept) begin
            oper_a_q <= grant ? Req1_OperA : Req0_OperA;
            oper_b_q <= grant ? Req1_OperB : Req0_OperB;
            code_q   <= grant ? Req1_Code  : Req0_Code;
        end
    end

    alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
        .OperA    (oper_a_q),
        .OperB    (oper_b_q),
        .ALU_Code (code_q),
        .Result   (alu_result),
        .Zero     (alu_z),
        .Negative (alu_n),
        .Carry    (alu_c),
        .Overflow (alu_v)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            result_q     <= '0;
            flags_q      <= '0;
            count_q      <= '0;
        end else begin
            if (accept) begin
                last_grant_q <= grant;
                id_q         <= grant;
            end
            case (state_q)
                ST_IDLE: if (accept) state_q <= ST_EXEC;
                ST_EXEC: begin
                    result_q    <= alu_result;
                    flags_q     <= flags_d;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: if (Rsp_Ready) begin
                    count_q     <= count_d;
                    rsp_valid_q <= 1'b0;
                    state_q     <= accept ? ST_EXEC : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Rsp_Valid  = rsp_valid_q;
    assign Rsp_Id     = rsp_id_q;
    assign Rsp_Result = result_q;
    assign Rsp_Flags  = flags_q;
    assign Op_Count   = count_q;
    assign Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter against a behavioural ALU/arbiter model.
module tb_alu_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Req0_Valid, Req0_Ready, Req1_Valid, Req1_Ready;
    logic [31:0] Req0_OperA, Req0_OperB, Req1_OperA, Req1_OperB;
    logic [1:0]  Req0_Code, Req1_Code;
    logic        Rsp_Valid, Rsp_Ready, Rsp_Id, Busy;
    logic [31:0] Rsp_Result;
    logic [3:0]  Rsp_Flags;
    logic [3:0]  Op_Count;

    int errors = 0;
    int checks = 0;
    bit lastg;
    int cnt_m;
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic [1:0]  pc [2];

    alu_arbiter #(.WIDTH(32), .CNT_W(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_OperA(Req0_OperA),
        .Req0_OperB(Req0_OperB), .Req0_Code(Req0_Code),
        .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_OperA(Req1_OperA),
        .Req1_OperB(Req1_OperB), .Req1_Code(Req1_Code),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Id(Rsp_Id),
        .Rsp_Result(Rsp_Result), .Rsp_Flags(Rsp_Flags), .Op_Count(Op_Count), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Model: {Z,N,C,V,result} from plain integer arithmetic
    function automatic logic [35:0] ref_alu(input logic [1:0] code, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, s;
        longint maxs, mins;
        logic [31:0] r;
        bit c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        maxs = 64'sh7FFF_FFFF;
        mins = -64'sh8000_0000;
        c = 0; v = 0; r = 0;
        case (code)
            2'b00: begin
                r = a + b;
                c = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
                s = sa + sb;
                v = (s > maxs) || (s < mins);
            end
            2'b01: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > maxs) || (s < mins);
            end
            2'b10: r = a & b;
            default: r = a | b;
        endcase
        return {(r == 0), r[31], c, v, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input bit p, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] c);
        if (!p) begin
            Req0_Valid = v; Req0_OperA = a; Req0_OperB = b; Req0_Code = c;
        end else begin
            Req1_Valid = v; Req1_OperA = a; Req1_OperB = b; Req1_Code = c;
        end
        pa[p] = a; pb[p] = b; pc[p] = c;
    endtask

    function automatic logic rdy(input bit p);
        return p ? Req1_Ready : Req0_Ready;
    endfunction

    task automatic do_reset();
        Reset_n = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        lastg = 1'b1;
        cnt_m = 0;
    endtask

    // Single-requester operation from IDLE with the consumer always ready
    task automatic do_op(input bit p, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] c);
        logic [35:0] e;
        e = ref_alu(c, a, b);
        drive(p, 1'b1, a, b, c);
        #1;
        chk("op_ready", rdy(p), 1'b1);
        chk("op_other_ready", rdy(!p), 1'b0);
        tick();
        lastg = p;
        drive(p, 1'b0, $urandom, $urandom, 2'($urandom_range(0, 3)));
        chk("op_exec_valid", Rsp_Valid, 1'b0);
        chk("op_exec_busy", Busy, 1'b1);
        tick();
        chk("op_rsp_valid", Rsp_Valid, 1'b1);
        chk("op_rsp_id", Rsp_Id, p);
        chk("op_rsp_result", Rsp_Result, e[31:0]);
        chk("op_rsp_flags", Rsp_Flags, e[35:32]);
        tick();
        cnt_m = (cnt_m + 1) % 16;
        chk("op_count", Op_Count, cnt_m);
        chk("op_idle_busy", Busy, 1'b0);
    endtask

    initial begin
        logic [35:0] e;
        bit g;
        Reset_n = 1'b1;
        Rsp_Ready = 1'b1;
        drive(0, 1'b1, 32'd1, 32'd2, 2'b00);
        drive(1, 1'b1, 32'd3, 32'd4, 2'b00);
        #1 Reset_n = 1'b0;
        #1;
        chk("rst_rsp_valid", Rsp_Valid, 1'b0);
        chk("rst_rsp_id", Rsp_Id, 1'b0);
        chk("rst_rsp_result", Rsp_Result, 32'd0);
        chk("rst_rsp_flags", Rsp_Flags, 4'd0);
        chk("rst_op_count", Op_Count, 4'd0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_ready0", Req0_Ready, 1'b0);
        chk("rst_ready1", Req1_Ready, 1'b0);
        Req0_Valid = 1'b0;
        Req1_Valid = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        lastg = 1'b1;
        cnt_m = 0;

        do_op(0, 32'd4, 32'd8, 2'b00);
        do_op(1, 32'd4, 32'd8, 2'b01);
        do_op(0, 32'h7FFF_FFFF, 32'd1, 2'b00);
        do_op(1, 32'd5, 32'd5, 2'b01);
        do_op(0, 32'hF0F0_1234, 32'h0FF0_FFFF, 2'b10);
        do_op(1, 32'hF0F0_0000, 32'h0000_000F, 2'b11);
        do_op(0, 32'h8000_0000, 32'd1, 2'b01);

        // Both requesters held valid: grants must alternate 0,1,0,1 from reset
        do_reset();
        drive(0, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
        drive(1, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
        #1;
        for (int i = 0; i < 4; i++) begin
            g = !lastg;
            chk("alt_ready0", Req0_Ready, g == 0);
            chk("alt_ready1", Req1_Ready, g == 1);
            e = ref_alu(pc[g], pa[g], pb[g]);
            tick();
            if (i > 0) cnt_m = (cnt_m + 1) % 16;
            lastg = g;
            drive(g, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
            chk("alt_exec_valid", Rsp_Valid, 1'b0);
            chk("alt_exec_ready", {Req0_Ready, Req1_Ready}, 2'b00);
            chk("alt_count", Op_Count, cnt_m);
            tick();
            chk("alt_rsp_valid", Rsp_Valid, 1'b1);
            chk("alt_rsp_id", Rsp_Id, g);
            chk("alt_rsp_result", Rsp_Result, e[31:0]);
            chk("alt_rsp_flags", Rsp_Flags, e[35:32]);
        end
        Req0_Valid = 1'b0;
        Req1_Valid = 1'b0;
        tick();
        cnt_m = (cnt_m + 1) % 16;
        chk("alt_end_count", Op_Count, cnt_m);
        chk("alt_end_busy", Busy, 1'b0);

        // Consumer stall: response held, no new grants
        drive(0, 1'b1, 32'hDEAD_0001, 32'h0000_0003, 2'b01);
        e = ref_alu(pc[0], pa[0], pb[0]);
        tick();
        lastg = 0;
        Req1_Valid = 1'b1;
        Rsp_Ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", Rsp_Valid, 1'b1);
            chk("stall_result", Rsp_Result, e[31:0]);
            chk("stall_flags", Rsp_Flags, e[35:32]);
            chk("stall_id", Rsp_Id, 1'b0);
            chk("stall_ready", {Req0_Ready, Req1_Ready}, 2'b00);
            chk("stall_busy", Busy, 1'b1);
            tick();
        end
        Req0_Valid = 1'b0;
        Req1_Valid = 1'b0;
        Rsp_Ready = 1'b1;
        tick();
        cnt_m = (cnt_m + 1) % 16;
        chk("stall_end_count", Op_Count, cnt_m);
        chk("stall_end_valid", Rsp_Valid, 1'b0);

        // Reset while an operation sits in EXEC
        drive(1, 1'b1, 32'd9, 32'd9, 2'b00);
        tick();
        Reset_n = 1'b0;
        Req0_Valid = 1'b1;
        #1;
        chk("rexec_valid", Rsp_Valid, 1'b0);
        chk("rexec_result", Rsp_Result, 32'd0);
        chk("rexec_flags", Rsp_Flags, 4'd0);
        chk("rexec_id", Rsp_Id, 1'b0);
        chk("rexec_count", Op_Count, 4'd0);
        chk("rexec_busy", Busy, 1'b0);
        chk("rexec_ready", {Req0_Ready, Req1_Ready}, 2'b00);
        tick();
        tick();
        chk("rexec_hold_valid", Rsp_Valid, 1'b0);
        Reset_n = 1'b1;
        lastg = 1'b1;
        cnt_m = 0;
        #1;
        chk("post_rst_ready0", Req0_Ready, 1'b1);
        chk("post_rst_ready1", Req1_Ready, 1'b0);
        Req1_Valid = 1'b0;
        do_op(0, Req0_OperA, Req0_OperB, Req0_Code);

        // Random traffic; the 4-bit counter wraps 15 -> 0 -> 1 along the way
        for (int i = 0; i < 24; i++) begin
            do_op(1'($urandom_range(0, 1)), $urandom,
                  (i % 5 == 0) ? 32'd0 : $urandom, 2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit combinational ALU between two requesters, the execute stage (port 0) and the address/branch unit (port 1). It runs a round-robin arbiter with valid/ready handshakes and registers operands before the ALU and results after it. It returns one tagged result, with Zero/Negative/Carry/Overflow flags, per accepted operation. It sits between the requesters and the ALU instance and owns all sequencing of that ALU.

## Interface
- WIDTH, 32, operand/result width
- CNT_W, 16, completed-operation counter width
- Clk  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Req0_Valid / Req1_Valid  in  1  request present; must stay high with stable payload until accepted
- Req0_Ready / Req1_Ready  out  1  request accepted this cycle when high together with Valid
- Req0_OperA, Req0_OperB / Req1_OperA, Req1_OperB  in  WIDTH  operands
- Req0_Code / Req1_Code  in  2  ALU operation code
- Rsp_Valid  out  1  result available
- Rsp_Ready  in  1  consumer takes the result
- Rsp_Id  out  1  index of the requester that owns the result
- Rsp_Result  out  WIDTH  registered ALU result
- Rsp_Flags  out  4  {Zero, Negative, Carry, Overflow}, registered
- Op_Count  out  CNT_W  completed operations; wraps to 0
- Busy  out  1  high when state is not IDLE

## Operation
- FSM has three states:
  - IDLE: no operation in flight.
  - EXEC: the operand registers drive the ALU.
  - RESP: the result is held on the outputs.
- Grant is computed combinationally from Last_Grant (1 bit).
  - With a single requester valid, that requester is granted.
  - With both valid, the requester ≠ Last_Grant is granted.
- Req_Ready(i) = grant==i AND (state==IDLE OR (state==RESP AND Rsp_Ready)). The non-granted Ready is 0.
- On accept:
  - latch OperA, OperB and Code into the operand registers;
  - latch the grant index into Id_Reg;
  - set Last_Grant to the granted index;
  - go to EXEC.
- EXEC: capture the ALU outputs into Rsp_Result/Rsp_Flags, set Rsp_Valid, go to RESP. This state always lasts exactly 1 cycle.
- RESP: hold all Rsp_* outputs stable while Rsp_Ready=0.
- On RESP with Rsp_Ready=1:
  - increment Op_Count;
  - if a request is accepted in the same cycle, go to EXEC (Rsp_Valid drops for one cycle); otherwise go to IDLE.
- ALU encoding: 00 ADD, 01 SUB, 10 AND, 11 OR.
- Carry = carry-out of A+B (ADD) or of A+~B+1 (SUB). Carry and Overflow are 0 for AND/OR.
- Zero = (Result==0). Negative = Result[WIDTH-1].
- Overflow = signed two's-complement overflow of ADD/SUB.
- Op_Count wraps from 2^CNT_W−1 to 0 with no flag.
- Reset (any state, including mid-EXEC/RESP): the in-flight operation is discarded.
  - State→IDLE, Last_Grant→1 (so port 0 wins first).
  - Rsp_Valid=0, Rsp_Id=0, Rsp_Result=0, Rsp_Flags=0, Op_Count=0, Busy=0.
  - Req0_Ready=Req1_Ready=0 while Reset_n=0.
- Payload that changes after acceptance has no effect on the in-flight operation.

## Timing
- An accept at rising edge N gives Rsp_Valid=1 after edge N+1. Latency is 2 edges.
- Peak throughput is one operation per 2 cycles (RESP→EXEC chaining).
- Rsp_* outputs change only on the edge leaving EXEC, or on reset.
- Ready depends combinationally on Valid, state and Rsp_Ready. There is no combinational path from the Req operands to any output.
- The ALU sits between two register stages. The operand-to-result path is the only long path and fits one Clk period.

## Structure
- Shared package alu_pkg holds:
  - constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11;
  - FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0;
  - state encoding ST_IDLE, ST_EXEC, ST_RESP.
- One sub-module: the existing ALU (OperA, OperB, ALU_Code → Result, Zero, Negative, Carry, Overflow), instantiated once. It is not duplicated per requester.
- Arbiter logic and FSM stay inline in alu_arbiter.

## Test plan
- Req0 ADD, A=4, B=8, Rsp_Ready=1:
  - Rsp_Valid two edges after accept;
  - Rsp_Result=12, Rsp_Id=0, Rsp_Flags=0000, Op_Count=1.
- Req1 SUB, A=4, B=8:
  - Rsp_Result=0xFFFFFFFC, Flags Z=0 N=1 C=0 V=0, Rsp_Id=1.
- Req0 ADD, A=0x7FFFFFFF, B=1:
  - Result=0x80000000, N=1, V=1, C=0.
- SUB, A=5, B=5:
  - Z=1, C=1.
- Both Valid held continuously after reset:
  - grants alternate 0,1,0,1;
  - each op completes in 2 cycles with Rsp_Ready=1;
  - no requester is granted twice in a row.
- Rsp_Ready low for 5 cycles:
  - Rsp_Result/Id/Flags stay stable;
  - both Req_Ready stay 0;
  - Busy=1.
- Assert Reset_n=0 during EXEC:
  - all outputs go to 0 immediately; no response is ever produced for that op;
  - the first post-reset grant goes to port 0.
- Run 2^CNT_W+1 operations with CNT_W=4:
  - Op_Count passes 15→0→1.
